// File: rtl/mem_access_unit.sv
// Memory-stage access controller: passes ALU results to write-back, runs a
// req/ack transaction for loads and stores, and stalls upstream until it ends.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [15:0] ex_alu,
    input  logic [15:0] ex_sdata,
    input  logic        ex_we,
    input  logic [3:0]  ex_dst_addr,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] wb_data,
    output logic        wb_we,
    output logic [3:0]  wb_dst_addr,
    output logic        err,
    input  logic        err_clr
);

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_lat_we;
    logic        r_lat_load;
    logic [3:0]  r_lat_dst;
    logic        r_mem_req;
    logic        r_mem_wr;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic [15:0] r_wb_data;
    logic        r_wb_we;
    logic [3:0]  r_wb_dst;
    logic        r_err;

    logic w_memop;
    logic w_timeout_hit;

    assign w_memop       = ex_valid & (ex_is_load | ex_is_store);
    assign w_timeout_hit = TO_EN && (r_state == ST_REQ) && !mem_ack && (r_cnt == TO_LAST);

    // Combinational so upstream advances on the very edge the transaction ends.
    assign stall = ((r_state == ST_IDLE) & w_memop)
                 | ((r_state == ST_REQ) & ~mem_ack & ~w_timeout_hit);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; reset is synchronous and lives inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 16'd0;
            r_lat_we    <= 1'b0;
            r_lat_load  <= 1'b0;
            r_lat_dst   <= 4'd0;
            r_mem_req   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= 16'd0;
            r_mem_wdata <= 16'd0;
            r_wb_data   <= 16'd0;
            r_wb_we     <= 1'b0;
            r_wb_dst    <= 4'd0;
            r_err       <= 1'b0;
        end else begin
            // A timeout in the same cycle as err_clr must leave err set.
            r_err <= w_timeout_hit | (r_err & ~err_clr);

            case (r_state)
                ST_IDLE: begin
                    if (w_memop) begin
                        r_lat_we    <= ex_we;
                        r_lat_dst   <= ex_dst_addr;
                        r_lat_load  <= ex_is_load;
                        r_mem_addr  <= ex_alu;
                        r_mem_wdata <= ex_sdata;
                        r_mem_wr    <= ~ex_is_load;
                        r_mem_req   <= 1'b1;
                        r_wb_we     <= 1'b0;
                        r_cnt       <= 16'd0;
                        r_state     <= ST_REQ;
                    end else begin
                        r_wb_data <= ex_alu;
                        r_wb_we   <= ex_we & ex_valid;
                        r_wb_dst  <= ex_dst_addr;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_lat_load) begin
                            r_wb_data <= mem_rdata;
                            r_wb_we   <= r_lat_we;
                            r_wb_dst  <= r_lat_dst;
                        end else begin
                            r_wb_we <= 1'b0;
                        end
                        r_cnt   <= 16'd0;
                        r_state <= ST_IDLE;
                    end else if (w_timeout_hit) begin
                        r_mem_req <= 1'b0;
                        r_wb_we   <= 1'b0;
                        r_cnt     <= 16'd0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_wb_we <= 1'b0;
                        r_cnt   <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_wr      = r_mem_wr;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign wb_data     = r_wb_data;
    assign wb_we       = r_wb_we;
    assign wb_dst_addr = r_wb_dst;
    assign err         = r_err;

endmodule
